indirect_ram_ctrl: RTL and testbench
====================================

INDIRECT_RAM_CTRL -- requirements
Module: indirect_ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12: word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: word width.
REQ-003 SHALL have parameter LENGTH, default 1<<ADDR_WIDTH: number of implemented words, LENGTH <= 2^ADDR_WIDTH.
REQ-004 SHALL derive PTR_WORDS = ceil(ADDR_WIDTH/DATA_WIDTH) internally (2 at defaults).
REQ-005 clk  in  1  sole clock; all state changes on posedge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  request accepted when req_valid & req_ready at posedge.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_ind  in  1  1 = indirect, 0 = direct addressing.
REQ-011 req_addr  in  ADDR_WIDTH  target address (direct) or pointer location (indirect).
REQ-012 req_wdata  in  DATA_WIDTH  write data.
REQ-013 rsp_valid  out  1  response present.
REQ-014 rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at posedge.
REQ-015 rsp_rdata  out  DATA_WIDTH  read data; write data echoed for writes; 0 on error.
REQ-016 rsp_ptr  out  ADDR_WIDTH  effective address used.
REQ-017 rsp_err  out  1  effective address >= LENGTH.

Function
REQ-018 SHALL use FSM states IDLE, PTR, ACCESS, INC, RSP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is captured at acceptance and req_* are don't-care afterwards.
REQ-020 Direct: IDLE->ACCESS->RSP; rsp_valid SHALL rise 2 posedges after acceptance.
REQ-021 Indirect: IDLE->PTR (PTR_WORDS cycles)->ACCESS->RSP; pointer = little-endian concatenation of mem[req_addr+k], k=0..PTR_WORDS-1, truncated to ADDR_WIDTH; rsp_valid rises 2+PTR_WORDS posedges after acceptance.
REQ-022 Pointer-word addresses SHALL wrap modulo 2^ADDR_WIDTH; any pointer-word address >= LENGTH ends the request with rsp_err=1.
REQ-023 Effective address >= LENGTH SHALL give rsp_err=1, rsp_rdata=0, no memory write.
REQ-024 Writes SHALL commit at the ACCESS posedge, exactly once per request.
REQ-025 RSP SHALL hold rsp_valid, rsp_rdata, rsp_ptr and rsp_err stable until rsp_ready; on handshake go to IDLE with rsp_valid=0.
REQ-026 Responses SHALL be in request order, one per request; no outstanding overlap.
REQ-027 Outside RSP, rsp_valid=0 and rsp_* retain their last values.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_ptr=0, rsp_err=0.
REQ-029 Reset mid-operation SHALL abort the request without response; writes already committed remain; no later write occurs.
REQ-030 Memory contents SHALL NOT be reset.

Configuration
REQ-031 With RAM_AUTOINC_EN defined, indirect requests without error SHALL pass through INC after ACCESS, writing pointer+1 (mod 2^ADDR_WIDTH) back over PTR_WORDS cycles, adding PTR_WORDS cycles of latency; direct requests unaffected.
REQ-032 Without RAM_AUTOINC_EN, INC SHALL be unreachable and pointers never modified by the block.

Verification (defaults unless stated)
REQ-033 Direct write 0x010<=0xA5, then direct read 0x010 -> rsp_rdata=0xA5, rsp_ptr=0x010, rsp_err=0, rsp_valid 2 cycles after accept.
REQ-034 mem[0x020]=0x34, mem[0x021]=0x01, mem[0x134]=0x5C; indirect read 0x020 -> rsp_rdata=0x5C, rsp_ptr=0x134, rsp_valid 4 cycles after accept.
REQ-035 mem[0xFFF]=0x00, mem[0x000]=0x02; indirect write 0xFFF data 0x77 -> mem[0x200]=0x77, rsp_ptr=0x200.
REQ-036 LENGTH=3000, pointer 0xC00 -> rsp_err=1, rsp_rdata=0, memory unchanged; direct read 0xBB8 -> rsp_err=1.
REQ-037 rsp_ready low 5 cycles -> response stable, req_ready=0 throughout; pulse rst_n during PTR -> no response, no writes, outputs at reset values.
REQ-038 Indirect write via 0x020 (pointer 0x134) -> with RAM_AUTOINC_EN mem[0x020]=0x35, latency 6; without, mem[0x020]=0x34, latency 4.

Source files
------------

// File: rtl/indirect_ram_ctrl.sv
// indirect_ram_ctrl: single-port word RAM with direct and pointer-indirect request/response access.
// Optional feature macro: RAM_AUTOINC_EN (post-increments the stored pointer after indirect accesses).
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              request handshake (ready only while idle)
//   req_we, req_ind                  write select, indirect-addressing select
//   req_addr, req_wdata              target address or pointer location, write data
//   rsp_valid/rsp_ready              response handshake
//   rsp_rdata, rsp_ptr, rsp_err      read data (write echo, 0 on error), effective address, range error
module indirect_ram_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic                  req_ind,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] rsp_ptr,
    output logic                  rsp_err
);
    localparam int PTR_WORDS = (ADDR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int PW = PTR_WORDS * DATA_WIDTH;
    localparam int KW = $clog2(PTR_WORDS + 1);
`ifdef RAM_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, PTR, ACCESS, INC, RSP} state_t;
    state_t state, state_nx;
    logic [DATA_WIDTH-1:0] mem [LENGTH];
    logic                  we_q, ind_q;
    logic [ADDR_WIDTH-1:0] addr_q, ptr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [KW-1:0]         k;
    logic [ADDR_WIDTH-1:0] word_addr, eff, rd_addr, mem_waddr;
    logic [PW-1:0]         inc_word;
    logic [DATA_WIDTH-1:0] rd, mem_wdata;
    logic                  word_ok, eff_ok, last_k, mem_we;
    // pointer words sit at consecutive addresses that wrap modulo 2^ADDR_WIDTH
    assign word_addr = addr_q + ADDR_WIDTH'(k);
    assign eff       = ind_q ? ptr_q : addr_q;
    assign word_ok   = int'(word_addr) < LENGTH;
    assign eff_ok    = int'(eff) < LENGTH;
    assign last_k    = k == KW'(PTR_WORDS - 1);
    assign inc_word  = PW'(ptr_q + ADDR_WIDTH'(1));
    assign rd_addr   = state == ACCESS ? eff : word_addr;
    assign rd        = mem[rd_addr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = req_valid ? (req_ind ? PTR : ACCESS) : IDLE;
            PTR:     state_nx = !word_ok ? RSP : (last_k ? ACCESS : PTR);
            ACCESS:  state_nx = (AUTOINC && ind_q && eff_ok) ? INC : RSP;
            INC:     state_nx = last_k ? RSP : INC;
            RSP:     state_nx = rsp_ready ? IDLE : RSP;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        req_ready = state == IDLE;
        rsp_valid = state == RSP;
        mem_we    = (state == ACCESS && we_q && eff_ok) || state == INC;
        mem_waddr = state == INC ? word_addr : eff;
        mem_wdata = state == INC ? inc_word[k*DATA_WIDTH +: DATA_WIDTH] : wdata_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            ind_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ptr_q     <= '0;
            k         <= '0;
            rsp_rdata <= '0;
            rsp_ptr   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    k     <= '0;
                    ptr_q <= '0;
                    if (req_valid) begin
                        we_q    <= req_we;
                        ind_q   <= req_ind;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                    end
                end
                PTR: begin
                    // little-endian assembly; bits beyond ADDR_WIDTH are dropped
                    if (!word_ok) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_ptr   <= word_addr;
                    end else begin
                        ptr_q <= ptr_q | ADDR_WIDTH'(PW'(rd) << (k * DATA_WIDTH));
                        k     <= last_k ? '0 : k + KW'(1);
                    end
                end
                ACCESS: begin
                    rsp_ptr   <= eff;
                    rsp_err   <= !eff_ok;
                    rsp_rdata <= !eff_ok ? '0 : (we_q ? wdata_q : rd);
                    k         <= '0;
                end
                INC: k <= k + KW'(1);
                default: ;
            endcase
        end
    end
    // contents are deliberately outside the reset domain
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end
endmodule

// File: tb/tb_indirect_ram_ctrl.sv
module tb_indirect_ram_ctrl;
`ifdef RAM_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid [2];
    logic       req_ready [2];
    logic       req_we    [2];
    logic       req_ind   [2];
    logic [11:0] req_addr [2];
    logic [7:0] req_wdata [2];
    logic       rsp_valid [2];
    logic       rsp_ready [2];
    logic [7:0] rsp_rdata [2];
    logic [11:0] rsp_ptr  [2];
    logic       rsp_err   [2];
    logic [7:0] mdl   [2][4096];
    bit         known [2][4096];
    int         len   [2] = '{4096, 3000};
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    indirect_ram_ctrl u_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]), .req_ind(req_ind[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_ptr(rsp_ptr[0]), .rsp_err(rsp_err[0])
    );

    indirect_ram_ctrl #(.LENGTH(3000)) u_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]), .req_ind(req_ind[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_ptr(rsp_ptr[1]), .rsp_err(rsp_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference behaviour: resolve pointer by byte arithmetic, apply access, optional post-increment
    task automatic model(input int d, input bit we, input bit ind, input int addr, input int wd,
                         output int er, output int ep, output int ee, output int el,
                         output bit ck_d, output bit ck_p, output bit ck_l);
        int p, a, q;
        ck_d = 1; ck_p = 1; ck_l = 1; ee = 0; er = 0; el = 2; p = addr; ep = 0;
        if (ind) begin
            p = 0;
            el = 4;
            for (int i = 0; i < 2; i++) begin
                a = (addr + i) % 4096;
                if (a >= len[d]) begin
                    ee = 1; ck_p = 0; ck_l = 0;
                    return;
                end
                p += int'(mdl[d][a]) << (8 * i);
            end
            p = p % 4096;
        end
        ep = p;
        if (p >= len[d]) begin
            ee = 1;
            return;
        end
        if (we) begin
            mdl[d][p] = wd[7:0];
            known[d][p] = 1;
            er = wd;
        end else begin
            er = int'(mdl[d][p]);
            ck_d = known[d][p];
        end
        if (AUTOINC && ind) begin
            q = (p + 1) % 4096;
            for (int i = 0; i < 2; i++) mdl[d][(addr + i) % 4096] = 8'(q >> (8 * i));
            el += 2;
        end
    endtask

    task automatic run(input int d, input bit we, input bit ind, input int addr, input int wd, input int hold);
        int er, ep, ee, el, n;
        bit ck_d, ck_p, ck_l;
        logic [7:0] r0;
        logic [11:0] p0;
        logic e0;
        model(d, we, ind, addr, wd, er, ep, ee, el, ck_d, ck_p, ck_l);
        @(negedge clk);
        chk("req_ready_idle", req_ready[d], 1);
        req_valid[d] = 1; req_we[d] = we; req_ind[d] = ind;
        req_addr[d] = 12'(addr); req_wdata[d] = 8'(wd); rsp_ready[d] = 0;
        @(posedge clk);
        #1;
        req_valid[d] = 0; req_we[d] = 1'($urandom); req_ind[d] = 1'($urandom);
        req_addr[d] = 12'($urandom); req_wdata[d] = 8'($urandom);
        n = 1;
        while (!rsp_valid[d] && n < 40) begin
            chk("req_ready_busy", req_ready[d], 0);
            @(posedge clk);
            #1;
            n++;
        end
        chk("rsp_seen", rsp_valid[d], 1);
        if (ck_l) chk("latency", n, el);
        chk("rsp_err", rsp_err[d], ee);
        if (ck_p) chk("rsp_ptr", rsp_ptr[d], ep);
        if (ck_d) chk("rsp_rdata", rsp_rdata[d], er);
        r0 = rsp_rdata[d]; p0 = rsp_ptr[d]; e0 = rsp_err[d];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", rsp_valid[d], 1);
            chk("hold_ready", req_ready[d], 0);
            chk("hold_rdata", rsp_rdata[d], r0);
            chk("hold_ptr", rsp_ptr[d], p0);
            chk("hold_err", rsp_err[d], e0);
        end
        @(negedge clk);
        rsp_ready[d] = 1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 0;
        chk("post_valid", rsp_valid[d], 0);
        chk("post_ready", req_ready[d], 1);
        chk("post_rdata", rsp_rdata[d], r0);
    endtask

    initial begin
        int p, a;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 0; req_we[d] = 0; req_ind[d] = 0;
            req_addr[d] = 0; req_wdata[d] = 0; rsp_ready[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", rsp_valid[d], 0);
            chk("rst_rdata", rsp_rdata[d], 0);
            chk("rst_ptr", rsp_ptr[d], 0);
            chk("rst_err", rsp_err[d], 0);
        end
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("rst_ready_a", req_ready[0], 1);
        chk("rst_ready_b", req_ready[1], 1);

        run(0, 1, 0, 'h010, 'hA5, 0);
        run(0, 0, 0, 'h010, 0, 5);
        run(0, 1, 0, 'h020, 'h34, 0);
        run(0, 1, 0, 'h021, 'h01, 0);
        run(0, 1, 0, 'h134, 'h5C, 0);
        run(0, 0, 1, 'h020, 0, 1);
        run(0, 1, 0, 'hFFF, 'h00, 0);
        run(0, 1, 0, 'h000, 'h02, 0);
        run(0, 1, 1, 'hFFF, 'h77, 0);
        run(0, 0, 0, 'h200, 0, 0);
        run(0, 0, 0, 'hFFF, 0, 0);
        run(0, 1, 1, 'h020, 'h99, 2);
        run(0, 0, 0, 'h020, 0, 0);
        chk("autoinc_ptr_lo", mdl[0]['h020], AUTOINC ? 'h35 : 'h34);

        run(1, 1, 0, 'h030, 'h00, 0);
        run(1, 1, 0, 'h031, 'h0C, 0);
        run(1, 0, 1, 'h030, 0, 0);
        run(1, 1, 1, 'h030, 'h11, 0);
        run(1, 0, 0, 'hBB8, 0, 0);
        run(1, 1, 0, 'hBB8, 'h22, 0);
        run(1, 1, 0, 'hBB7, 'h05, 0);
        run(1, 0, 1, 'hBB7, 0, 0);
        run(1, 0, 0, 'h030, 0, 0);
        run(1, 0, 0, 'hBB7, 0, 0);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) run(d, 1, 0, 'h100 + i, int'($urandom_range(255)), 0);
            for (int i = 0; i < 16; i++) begin
                p = (d == 1 && i % 4 == 0) ? 3000 + int'($urandom_range(1000)) : 'h100 + int'($urandom_range(31));
                run(d, 1, 0, 'h040 + 2 * i, p & 'hFF, 0);
                run(d, 1, 0, 'h041 + 2 * i, p >> 8, 0);
            end
        end
        for (int t = 0; t < 200; t++) begin
            int d, kind, r;
            d = int'($urandom_range(1));
            kind = int'($urandom_range(3));
            r = int'($urandom);
            case (kind)
                0: run(d, 1, 0, 'h100 + (r & 31), (r >> 8) & 'hFF, r % 3);
                1: run(d, 0, 0, ((r >> 5) & 1) ? 'h040 + (r & 31) : 'h100 + (r & 31), 0, r % 3);
                2: run(d, 0, 1, 'h040 + 2 * (r & 15), 0, r % 3);
                default: run(d, 1, 1, 'h040 + 2 * (r & 15), (r >> 8) & 'hFF, r % 3);
            endcase
        end
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 32; i++) begin
                run(d, 0, 0, 'h100 + i, 0, 0);
                run(d, 0, 0, 'h040 + i, 0, 0);
            end

        // abort an indirect write while it is still fetching the pointer
        @(negedge clk);
        chk("abort_ready", req_ready[0], 1);
        req_valid[0] = 1; req_we[0] = 1; req_ind[0] = 1; req_addr[0] = 12'h020; req_wdata[0] = 8'hEE;
        @(posedge clk);
        #1;
        req_valid[0] = 0;
        #2;
        rst_n = 0;
        #1;
        chk("abort_valid", rsp_valid[0], 0);
        chk("abort_rdata", rsp_rdata[0], 0);
        chk("abort_ptr", rsp_ptr[0], 0);
        chk("abort_err", rsp_err[0], 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("abort_ready_rel", req_ready[0], 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_rsp", rsp_valid[0], 0);
        end
        a = int'(mdl[0]['h020]) | (int'(mdl[0]['h021]) << 8);
        run(0, 0, 0, 'h020, 0, 0);
        run(0, 0, 0, 'h021, 0, 0);
        run(0, 0, 0, a % 4096, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
